mac4b_exec_unit: RTL and testbench
==================================

Name: mac4b_exec_unit

Overview:
- Execution stage directly downstream of the CV-X-IF MAC 4-bit instruction decoder.
- Consumes issue transactions the decoder has accepted, together with the decoded destination register, operation code and source operands.
- Computes signed 4-bit-lane dot products with an internal accumulator in a 2-stage pipeline.
- Buffers results in an in-order result FIFO that drives the CV-X-IF result channel with valid/ready handshake.

Parameters:
XLEN, 32, operand/result width; must be a multiple of 4; lanes = XLEN/4.
IdWidth, 3, width of the instruction id tag.
FifoDepth, 4, result FIFO entries (power of two, >=2).

Ports:
clk_i  input  1  clock.
rst_ni  input  1  reset; asynchronous, active-low.
flush_i  input  1  synchronous discard of all in-flight work.
issue_valid_i  input  1  issue request valid.
issue_ready_o  output  1  block can take an issue this cycle.
issue_accept_i  input  1  decoder accepted the instruction.
issue_writeback_i  input  1  decoder writeback flag.
issue_op_i  input  2  0=DOT4B, 1=MAC4B, 2=RDACC, 3=CLRACC.
issue_rd_i  input  5  destination register from decoder.
issue_id_i  input  IdWidth  instruction id.
rs1_i  input  XLEN  source operand 1.
rs2_i  input  XLEN  source operand 2.
result_valid_o  output  1  result available.
result_ready_i  input  1  core consumes result.
result_id_o  output  IdWidth  id of the result.
result_rd_o  output  5  destination register.
result_we_o  output  1  register write enable (= latched writeback flag).
result_data_o  output  XLEN  result value.

Behaviour:
- Issue fire = issue_valid_i & issue_ready_o & issue_accept_i. Requests with accept=0 are ignored and consume no resources.
- issue_ready_o = (fifo_count + inflight) < FifoDepth, where inflight is the number of valid pipeline stages (0..2). This guarantees a slot for every in-flight op, so the pipeline never stalls.
- Stage 1 (registered on fire):
  - Lane products p[k] = signed(rs1[4k+3:4k]) * signed(rs2[4k+3:4k]), 8-bit signed each.
  - Register the products plus op, rd, id and writeback.
- Stage 2: dot = sign-extended sum of all p[k] to XLEN. Range -448..512 for XLEN=32.
- Result and accumulator effect per op (all arithmetic modulo 2^XLEN, wrap-around with no saturation):
  - DOT4B: result = dot; acc unchanged.
  - MAC4B: acc_next = acc + dot; result = acc_next.
  - RDACC: result = acc; acc unchanged.
  - CLRACC: result = acc (old value); acc_next = 0.
- The accumulator updates in stage 2 in program order, so back-to-back MAC4B ops chain correctly with no bubbles.
- The stage-2 output is written into the FIFO in the same cycle it computes. Issue-to-result_valid latency is 3 cycles when the FIFO is empty. Throughput is 1 op/cycle.
- FIFO is in-order. Head is presented on the result_* outputs. It pops when result_valid_o & result_ready_i.
- Simultaneous push and pop while full cannot occur because of the ready rule. Push and pop in the same cycle leave the count unchanged.
- result_* outputs are stable while result_valid_o=1 and result_ready_i=0.
- flush_i:
  - Clears pipeline valids, the FIFO (pointers and count) and any issue fire in the same cycle.
  - The accumulator is NOT modified by flush. Ops discarded before stage 2 never update it.
  - result_valid_o=0 in the cycle after flush.
- Reset (async assert, any time including mid-operation):
  - issue_ready_o=1 after reset.
  - result_valid_o=0; result_id_o, result_rd_o, result_we_o, result_data_o all 0.
  - Accumulator = 0; pipeline and FIFO empty.
- Assertions:
  - No FIFO overflow or underflow.
  - result_* stable under backpressure.
  - result_we_o matches the writeback flag of the corresponding issue.

Test Plan:
1. Reset, then DOT4B rs1=0x11111111, rs2=0x22222222, id=1, rd=5 -> 3 cycles later result_valid_o=1, data=16, rd=5, id=1, we=1.
2. DOT4B rs1=0x88888888, rs2=0x88888888 -> data=512. rs1=0x88888888, rs2=0x77777777 -> data=0xFFFFFE40 (-448).
3. CLRACC, then 3 back-to-back MAC4B each with rs1=0x00000011, rs2=0x00000011 (dot=2), then RDACC -> results 0(old),2,4,6,6 in issue order, ids preserved.
4. Hold result_ready_i=0 and issue continuously -> exactly FifoDepth results accepted. issue_ready_o drops when count+inflight=4 and rises one cycle after the first pop. Data is stable during the stall.
5. Issue with issue_accept_i=0 -> no result and no acc change. Issue with writeback=0 -> result returned with result_we_o=0.
6. MAC4B issued, then flush_i the next cycle -> no result_valid_o and acc unchanged (verified by RDACC). Async rst_ni pulse with FIFO half full -> all outputs 0 immediately, acc=0.

Source files
------------

// File: rtl/mac4b_exec_unit.sv
// CV-X-IF execution stage for the MAC 4-bit extension: signed 4-bit-lane dot products,
// a running accumulator and an in-order result FIFO feeding the result channel.

module mac4b_exec_unit #(
    parameter int XLEN      = 32,
    parameter int IdWidth   = 3,
    parameter int FifoDepth = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic               issue_accept_i,
    input  logic               issue_writeback_i,
    input  logic [1:0]         issue_op_i,
    input  logic [4:0]         issue_rd_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    rs1_i,
    input  logic [XLEN-1:0]    rs2_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [4:0]         result_rd_o,
    output logic               result_we_o,
    output logic [XLEN-1:0]    result_data_o
);

    localparam int LANES = XLEN / 4;
    localparam int PW    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CW    = PW + 1;

    localparam logic [1:0] OP_DOT4B  = 2'd0;
    localparam logic [1:0] OP_MAC4B  = 2'd1;
    localparam logic [1:0] OP_RDACC  = 2'd2;
    localparam logic [1:0] OP_CLRACC = 2'd3;

    function automatic logic [7:0] lane_mul(input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] a_ext;
        logic signed [7:0] b_ext;
        a_ext = {{4{a[3]}}, a};
        b_ext = {{4{b[3]}}, b};
        lane_mul = a_ext * b_ext;
    endfunction

    logic               fire_s;
    logic [7:0]         prod_s [LANES];
    logic [XLEN-1:0]    dot_s;

    logic               s1_valid_r;
    logic [7:0]         s1_prod_r [LANES];
    logic [1:0]         s1_op_r;
    logic [4:0]         s1_rd_r;
    logic [IdWidth-1:0] s1_id_r;
    logic               s1_we_r;

    logic               s2_valid_r;
    logic [XLEN-1:0]    s2_dot_r;
    logic [1:0]         s2_op_r;
    logic [4:0]         s2_rd_r;
    logic [IdWidth-1:0] s2_id_r;
    logic               s2_we_r;

    logic [XLEN-1:0]    acc_r;
    logic [XLEN-1:0]    acc_nxt_s;
    logic [XLEN-1:0]    res_s;

    logic [XLEN-1:0]    fifo_data_r [FifoDepth];
    logic [IdWidth-1:0] fifo_id_r   [FifoDepth];
    logic [4:0]         fifo_rd_r   [FifoDepth];
    logic [FifoDepth-1:0] fifo_we_r;
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [PW-1:0]      wr_ptr_nxt_s;
    logic [PW-1:0]      rd_ptr_nxt_s;
    logic [CW-1:0]      count_nxt_s;
    logic [CW:0]        occ_nxt_s;
    logic               push_s;
    logic               pop_s;
    logic               s2_in_s;
    logic               head_bypass_s;

    logic               issue_ready_r;
    logic               result_valid_r;
    logic [IdWidth-1:0] result_id_r;
    logic [4:0]         result_rd_r;
    logic               result_we_r;
    logic [XLEN-1:0]    result_data_r;

    assign fire_s  = issue_valid_i & issue_ready_r & issue_accept_i & ~flush_i;
    assign s2_in_s = s1_valid_r & ~flush_i;
    assign push_s  = s2_valid_r & ~flush_i;
    assign pop_s   = result_valid_r & result_ready_i & ~flush_i;

    // Per-lane signed products of the incoming operands
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prod_s[k] = lane_mul(rs1_i[4*k +: 4], rs2_i[4*k +: 4]);
        end
    end

    // Stage 1: capture products and instruction tag on issue fire
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 2'd0;
            s1_rd_r    <= 5'd0;
            s1_id_r    <= '0;
            s1_we_r    <= 1'b0;
            for (int k = 0; k < LANES; k++) s1_prod_r[k] <= 8'd0;
        end else begin
            s1_valid_r <= fire_s;
            if (fire_s) begin
                s1_op_r <= issue_op_i;
                s1_rd_r <= issue_rd_i;
                s1_id_r <= issue_id_i;
                s1_we_r <= issue_writeback_i;
                for (int k = 0; k < LANES; k++) s1_prod_r[k] <= prod_s[k];
            end
        end
    end

    // Sign-extended reduction of the stage-1 products
    always_comb begin
        dot_s = {XLEN{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            dot_s = dot_s + {{(XLEN-8){s1_prod_r[k][7]}}, s1_prod_r[k]};
        end
    end

    // Stage 2: hold the dot product and tag for the accumulate/writeback step
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_r <= 1'b0;
            s2_dot_r   <= {XLEN{1'b0}};
            s2_op_r    <= 2'd0;
            s2_rd_r    <= 5'd0;
            s2_id_r    <= '0;
            s2_we_r    <= 1'b0;
        end else begin
            s2_valid_r <= s2_in_s;
            if (s2_in_s) begin
                s2_dot_r <= dot_s;
                s2_op_r  <= s1_op_r;
                s2_rd_r  <= s1_rd_r;
                s2_id_r  <= s1_id_r;
                s2_we_r  <= s1_we_r;
            end
        end
    end

    // Result value and accumulator effect of the stage-2 op
    always_comb begin
        acc_nxt_s = acc_r;
        res_s     = acc_r;
        case (s2_op_r)
            OP_DOT4B: begin
                acc_nxt_s = acc_r;
                res_s     = s2_dot_r;
            end
            OP_MAC4B: begin
                acc_nxt_s = acc_r + s2_dot_r;
                res_s     = acc_r + s2_dot_r;
            end
            OP_RDACC: begin
                acc_nxt_s = acc_r;
                res_s     = acc_r;
            end
            OP_CLRACC: begin
                acc_nxt_s = {XLEN{1'b0}};
                res_s     = acc_r;
            end
            default: begin
                acc_nxt_s = acc_r;
                res_s     = acc_r;
            end
        endcase
    end

    // Accumulator only moves when its op actually retires into the FIFO
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_r <= {XLEN{1'b0}};
        end else if (push_s) begin
            acc_r <= acc_nxt_s;
        end
    end

    // Next FIFO pointers, occupancy and issue credit
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (flush_i) begin
            wr_ptr_nxt_s = {PW{1'b0}};
            rd_ptr_nxt_s = {PW{1'b0}};
            count_nxt_s  = {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_nxt_s = wr_ptr_r + PW'(1);
            else        wr_ptr_nxt_s = wr_ptr_r;
            if (pop_s)  rd_ptr_nxt_s = rd_ptr_r + PW'(1);
            else        rd_ptr_nxt_s = rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CW'(1);
                2'b01:   count_nxt_s = count_r - CW'(1);
                default: count_nxt_s = count_r;
            endcase
        end
        occ_nxt_s = {1'b0, count_nxt_s} + {{CW{1'b0}}, fire_s} + {{CW{1'b0}}, s2_in_s};
        // The new head is the entry being written when the FIFO is or becomes empty
        head_bypass_s = push_s & (rd_ptr_nxt_s == wr_ptr_r);
    end

    // FIFO storage and pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
            fifo_we_r <= {FifoDepth{1'b0}};
            for (int i = 0; i < FifoDepth; i++) begin
                fifo_data_r[i] <= {XLEN{1'b0}};
                fifo_id_r[i]   <= '0;
                fifo_rd_r[i]   <= 5'd0;
            end
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= res_s;
                fifo_id_r[wr_ptr_r]   <= s2_id_r;
                fifo_rd_r[wr_ptr_r]   <= s2_rd_r;
                fifo_we_r[wr_ptr_r]   <= s2_we_r;
            end
        end
    end

    // Registered result channel and issue-ready; head only changes on pop or fill-from-empty
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_ready_r  <= 1'b1;
            result_valid_r <= 1'b0;
            result_id_r    <= '0;
            result_rd_r    <= 5'd0;
            result_we_r    <= 1'b0;
            result_data_r  <= {XLEN{1'b0}};
        end else begin
            issue_ready_r  <= (occ_nxt_s < (CW+1)'(FifoDepth));
            result_valid_r <= (count_nxt_s != {CW{1'b0}});
            if (head_bypass_s) begin
                result_id_r   <= s2_id_r;
                result_rd_r   <= s2_rd_r;
                result_we_r   <= s2_we_r;
                result_data_r <= res_s;
            end else begin
                result_id_r   <= fifo_id_r[rd_ptr_nxt_s];
                result_rd_r   <= fifo_rd_r[rd_ptr_nxt_s];
                result_we_r   <= fifo_we_r[rd_ptr_nxt_s];
                result_data_r <= fifo_data_r[rd_ptr_nxt_s];
            end
        end
    end

    assign issue_ready_o  = issue_ready_r;
    assign result_valid_o = result_valid_r;
    assign result_id_o    = result_id_r;
    assign result_rd_o    = result_rd_r;
    assign result_we_o    = result_we_r;
    assign result_data_o  = result_data_r;

    mac4b_exec_unit_chk #(
        .XLEN      (XLEN),
        .IdWidth   (IdWidth),
        .FifoDepth (FifoDepth)
    ) u_chk (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .fire         (fire_s),
        .fire_we      (issue_writeback_i),
        .push         (push_s),
        .pop          (pop_s),
        .count        (count_r),
        .result_valid (result_valid_r),
        .result_ready (result_ready_i),
        .result_id    (result_id_r),
        .result_rd    (result_rd_r),
        .result_we    (result_we_r),
        .result_data  (result_data_r)
    );

endmodule

// Protocol checker: FIFO bounds, result stability under backpressure and
// writeback-flag tracking from issue to result.
module mac4b_exec_unit_chk #(
    parameter int XLEN      = 32,
    parameter int IdWidth   = 3,
    parameter int FifoDepth = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               fire,
    input  logic               fire_we,
    input  logic               push,
    input  logic               pop,
    input  logic [((FifoDepth > 1) ? $clog2(FifoDepth) : 1):0] count,
    input  logic               result_valid,
    input  logic               result_ready,
    input  logic [IdWidth-1:0] result_id,
    input  logic [4:0]         result_rd,
    input  logic               result_we,
    input  logic [XLEN-1:0]    result_data
);

    localparam int SPW = ((FifoDepth > 1) ? $clog2(FifoDepth) : 1) + 1;
    localparam int CW  = SPW;

    logic [(1 << SPW)-1:0] sh_we_r;
    logic [SPW-1:0]        sh_wr_r;
    logic [SPW-1:0]        sh_rd_r;

    // Shadow queue of writeback flags in issue order
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_we_r <= '0;
            sh_wr_r <= {SPW{1'b0}};
            sh_rd_r <= {SPW{1'b0}};
        end else if (flush_i) begin
            sh_wr_r <= {SPW{1'b0}};
            sh_rd_r <= {SPW{1'b0}};
        end else begin
            if (fire) begin
                sh_we_r[sh_wr_r] <= fire_we;
                sh_wr_r          <= sh_wr_r + SPW'(1);
            end
            if (pop) sh_rd_r <= sh_rd_r + SPW'(1);
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && (count == CW'(FifoDepth))));

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && (count == {CW{1'b0}})));

    a_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (result_valid && !result_ready && !flush_i) |=>
        (result_valid && $stable(result_data) && $stable(result_id) &&
         $stable(result_rd) && $stable(result_we)));

    a_we_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop |-> (result_we == sh_we_r[sh_rd_r]));

endmodule

// File: tb/tb_mac4b_exec_unit.sv
// Directed scoreboard bench for mac4b_exec_unit.
module tb_mac4b_exec_unit;

    localparam int XLEN = 32;
    localparam int IW   = 3;
    localparam int D    = 4;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic            issue_valid_i = 1'b0;
    logic            issue_ready_o;
    logic            issue_accept_i = 1'b0;
    logic            issue_writeback_i = 1'b0;
    logic [1:0]      issue_op_i = 2'd0;
    logic [4:0]      issue_rd_i = 5'd0;
    logic [IW-1:0]   issue_id_i = '0;
    logic [XLEN-1:0] rs1_i = '0;
    logic [XLEN-1:0] rs2_i = '0;
    logic            result_valid_o;
    logic            result_ready_i = 1'b1;
    logic [IW-1:0]   result_id_o;
    logic [4:0]      result_rd_o;
    logic            result_we_o;
    logic [XLEN-1:0] result_data_o;

    typedef struct {
        logic [IW-1:0]   id;
        logic [4:0]      rd;
        logic            we;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   nfired;
    logic fired;

    mac4b_exec_unit #(.XLEN(XLEN), .IdWidth(IW), .FifoDepth(D)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_accept_i    (issue_accept_i),
        .issue_writeback_i (issue_writeback_i),
        .issue_op_i        (issue_op_i),
        .issue_rd_i        (issue_rd_i),
        .issue_id_i        (issue_id_i),
        .rs1_i             (rs1_i),
        .rs2_i             (rs2_i),
        .result_valid_o    (result_valid_o),
        .result_ready_i    (result_ready_i),
        .result_id_o       (result_id_o),
        .result_rd_o       (result_rd_o),
        .result_we_o       (result_we_o),
        .result_data_o     (result_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One-cycle issue attempt; fired reports whether the DUT took it
    task automatic drive(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [IW-1:0] id, input logic [4:0] rd, input logic wb,
                         input logic acc, input logic [XLEN-1:0] exp_data, input logic track,
                         output logic fired_o);
        exp_t e;
        issue_valid_i     = 1'b1;
        issue_accept_i    = acc;
        issue_op_i        = op;
        rs1_i             = a;
        rs2_i             = b;
        issue_id_i        = id;
        issue_rd_i        = rd;
        issue_writeback_i = wb;
        fired_o = issue_ready_o & acc;
        if (fired_o && track) begin
            e.id = id; e.rd = rd; e.we = wb; e.data = exp_data;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        issue_valid_i  = 1'b0;
        issue_accept_i = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [IW-1:0] id, input logic [4:0] rd, input logic wb,
                         input logic [XLEN-1:0] exp_data, input logic track);
        int n;
        logic f;
        n = 0;
        while (!issue_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        drive(op, a, b, id, rd, wb, 1'b1, exp_data, track, f);
        tests++;
        if (!f) begin
            fails++;
            $display("FAIL issue_accept: got fired=%0b expected 1", f);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || result_valid_o) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
        end
    endtask

    // Scoreboard monitor: compare each handshaked result against the queue head
    always @(negedge clk) begin
        if (rst_ni && result_valid_o && result_ready_i) begin
            exp_t e;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got id=%0d data=0x%08h expected no result",
                         result_id_o, result_data_o);
            end else begin
                e = sb.pop_front();
                if (result_id_o !== e.id || result_rd_o !== e.rd ||
                    result_we_o !== e.we || result_data_o !== e.data) begin
                    fails++;
                    $display("FAIL result: got id=%0d rd=%0d we=%0b data=0x%08h expected id=%0d rd=%0d we=%0b data=0x%08h",
                             result_id_o, result_rd_o, result_we_o, result_data_o,
                             e.id, e.rd, e.we, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, result_valid_o}, 32'd0);
        check("rst_ready", {31'd0, issue_ready_o}, 32'd1);
        check("rst_data", result_data_o, 32'd0);
        check("rst_tag", {23'd0, result_id_o, result_rd_o, result_we_o}, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Basic DOT4B with latency check
        issue(2'd0, 32'h11111111, 32'h22222222, 3'd1, 5'd5, 1'b1, 32'd16, 1'b1);
        check("lat_c1", {31'd0, result_valid_o}, 32'd0);
        @(posedge clk); #1;
        check("lat_c2", {31'd0, result_valid_o}, 32'd0);
        @(posedge clk); #1;
        check("lat_c3", {31'd0, result_valid_o}, 32'd1);
        wait_drain();

        // Extreme lane values
        issue(2'd0, 32'h88888888, 32'h88888888, 3'd2, 5'd6, 1'b1, 32'd512, 1'b1);
        issue(2'd0, 32'h88888888, 32'h77777777, 3'd3, 5'd7, 1'b1, 32'hFFFFFE40, 1'b1);
        wait_drain();

        // Accumulator chaining
        issue(2'd3, 32'd0, 32'd0, 3'd4, 5'd1, 1'b1, 32'd0, 1'b1);
        issue(2'd1, 32'h11, 32'h11, 3'd5, 5'd2, 1'b1, 32'd2, 1'b1);
        issue(2'd1, 32'h11, 32'h11, 3'd6, 5'd3, 1'b1, 32'd4, 1'b1);
        issue(2'd1, 32'h11, 32'h11, 3'd7, 5'd4, 1'b1, 32'd6, 1'b1);
        issue(2'd2, 32'd0, 32'd0, 3'd0, 5'd8, 1'b1, 32'd6, 1'b1);
        wait_drain();

        // Backpressure: continuous issue with result_ready low
        result_ready_i = 1'b0;
        nfired = 0;
        for (int k = 1; k <= 6; k++) begin
            drive(2'd0, 32'd1, 32'(k), 3'(k), 5'(k), 1'b1, 1'b1, 32'(k), 1'b1, fired);
            if (fired) nfired++;
        end
        check("bp_fired", 32'(nfired), 32'd4);
        check("bp_ready_low", {31'd0, issue_ready_o}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("bp_stall_ready", {31'd0, issue_ready_o}, 32'd0);
            check("bp_stall_valid", {31'd0, result_valid_o}, 32'd1);
            check("bp_stall_data", result_data_o, 32'd1);
        end
        result_ready_i = 1'b1;
        check("bp_pop_ready", {31'd0, issue_ready_o}, 32'd0);
        @(posedge clk); #1;
        check("bp_after_pop_ready", {31'd0, issue_ready_o}, 32'd1);
        wait_drain();

        // accept=0 is ignored; writeback=0 propagates
        drive(2'd1, 32'h11, 32'h11, 3'd3, 5'd3, 1'b1, 1'b0, 32'd0, 1'b0, fired);
        repeat (5) @(posedge clk);
        #1;
        check("noaccept_valid", {31'd0, result_valid_o}, 32'd0);
        issue(2'd2, 32'd0, 32'd0, 3'd1, 5'd10, 1'b1, 32'd6, 1'b1);
        issue(2'd0, 32'h11111111, 32'h22222222, 3'd2, 5'd9, 1'b0, 32'd16, 1'b1);
        wait_drain();

        // Flush discards an in-flight MAC without touching the accumulator
        issue(2'd1, 32'h11, 32'h11, 3'd4, 5'd11, 1'b1, 32'd8, 1'b0);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush_valid0", {31'd0, result_valid_o}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("flush_valid", {31'd0, result_valid_o}, 32'd0);
        issue(2'd2, 32'd0, 32'd0, 3'd5, 5'd12, 1'b1, 32'd6, 1'b1);
        wait_drain();

        // Async reset with results pending
        result_ready_i = 1'b0;
        issue(2'd0, 32'h11111111, 32'h22222222, 3'd3, 5'd13, 1'b1, 32'd16, 1'b0);
        issue(2'd0, 32'h11111111, 32'h22222222, 3'd4, 5'd14, 1'b1, 32'd16, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_valid", {31'd0, result_valid_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", {31'd0, result_valid_o}, 32'd0);
        check("arst_data", result_data_o, 32'd0);
        check("arst_tag", {23'd0, result_id_o, result_rd_o, result_we_o}, 32'd0);
        check("arst_ready", {31'd0, issue_ready_o}, 32'd1);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        result_ready_i = 1'b1;
        @(posedge clk); #1;
        issue(2'd2, 32'd0, 32'd0, 3'd6, 5'd15, 1'b1, 32'd0, 1'b1);
        issue(2'd1, 32'h11, 32'h11, 3'd7, 5'd16, 1'b1, 32'd2, 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
